// File: rtl/channel_loop_sequencer_pkg.sv
// Shared definitions for the conv-layer channel loop sequencer: phase-strobe encoding and
// width helpers common to the sequencer and the layer controller.
package channel_loop_sequencer_pkg;

   localparam int unsigned NumStrobes = 5;

   // Bit positions of the phase strobes in the packed strobe vector.
   typedef enum int unsigned {
      StrbCout  = 0,
      StrbCLoad = 1,
      StrbCin   = 2,
      StrbConv  = 3,
      StrbPool  = 4
   } strobe_e;

   function automatic int unsigned co_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic multi_hot(input logic [NumStrobes-1:0] s);
      return (s & (s - NumStrobes'(1))) != '0;
   endfunction

endpackage

// File: rtl/channel_loop_sequencer_addr.sv
// Base-address register with load / step-by-STRIDE / hold; keeps address math multiplier-free.
module stride_addr_gen #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned STRIDE = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] q_o
);

   logic [ADDR_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (step_i) begin
         q_d = q_q + ADDR_W'(STRIDE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/channel_loop_sequencer.sv
// Responder for the conv-layer phase handshake: owns channel counters and per-pass base
// addresses, reports loop status and flags handshake violations.
module channel_loop_sequencer
   import channel_loop_sequencer_pkg::*;
#(
   parameter int unsigned NUM_IN_CH    = 3,
   parameter int unsigned NUM_OUT_CH   = 2,
   parameter int unsigned KERNEL_WORDS = 9,
   parameter int unsigned IFMAP_WORDS  = 64,
   parameter int unsigned OFMAP_WORDS  = 16,
   parameter int unsigned ADDR_W       = 16,
   localparam int unsigned CI_W        = $clog2(NUM_IN_CH + 1),
   localparam int unsigned CO_W        = co_width(NUM_OUT_CH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cout_i,
   input  logic              c_load_i,
   input  logic              cin_i,
   input  logic              conv_i,
   input  logic              pool_i,
   output logic              cin_done_o,
   output logic              cout_done_o,
   output logic              is_single_input_channel_o,
   output logic [CI_W-1:0]   ci_idx_o,
   output logic [CO_W-1:0]   co_idx_o,
   output logic [ADDR_W-1:0] w_base_o,
   output logic [ADDR_W-1:0] if_base_o,
   output logic [ADDR_W-1:0] of_base_o,
   output logic              first_pass_o,
   output logic              last_pass_o,
   output logic              all_done_o,
   output logic              proto_err_o
);

   localparam bit                Single    = (NUM_IN_CH == 1);
   localparam logic [CI_W-1:0]   CiMax     = CI_W'(NUM_IN_CH);
   localparam logic [CI_W-1:0]   CiLast    = CI_W'(NUM_IN_CH - 1);
   localparam logic [CO_W-1:0]   CoLast    = CO_W'(NUM_OUT_CH - 1);
   localparam logic [ADDR_W-1:0] WCoStride = ADDR_W'(NUM_IN_CH * KERNEL_WORDS);

   logic [CI_W-1:0]   ci_cnt_q, ci_cnt_d, ci_idx_q, ci_idx_d;
   logic [CO_W-1:0]   co_idx_q, co_idx_d;
   logic [ADDR_W-1:0] w_co_base_q, w_co_base_d;
   logic              first_pass_q, first_pass_d, last_pass_q, last_pass_d;
   logic              all_done_q, all_done_d, proto_err_q, proto_err_d;
   logic              cin_done_seen_q, cin_done_seen_d;
   logic              cin_done, cout_done, ci_step, co_step;
   logic [NumStrobes-1:0] strobes;

   assign strobes   = {pool_i, conv_i, cin_i, c_load_i, cout_i};
   assign cin_done  = !Single && (ci_cnt_q == CiMax);
   assign cout_done = (co_idx_q == CoLast);

   // The first cin of a pass only counts; bases stay where c_load put them.
   assign ci_step = !c_load_i && cin_i && !cin_done && (ci_cnt_q != '0);
   assign co_step = !c_load_i && !cin_i && cout_i && !cout_done;

   always_comb begin
      ci_cnt_d     = ci_cnt_q;
      ci_idx_d     = ci_idx_q;
      co_idx_d     = co_idx_q;
      w_co_base_d  = w_co_base_q;
      first_pass_d = first_pass_q;
      last_pass_d  = last_pass_q;
      all_done_d   = all_done_q;
      if (c_load_i) begin
         ci_cnt_d     = '0;
         ci_idx_d     = '0;
         first_pass_d = 1'b1;
         last_pass_d  = Single;
      end else if (cin_i) begin
         if (!cin_done) begin
            ci_cnt_d    = ci_cnt_q + CI_W'(1);
            last_pass_d = (ci_cnt_q == CiLast);
            if (ci_cnt_q != '0) begin
               ci_idx_d     = ci_cnt_q;
               first_pass_d = 1'b0;
            end
         end
      end else if (cout_i) begin
         if (cout_done) begin
            all_done_d = 1'b1;
         end else begin
            co_idx_d    = co_idx_q + CO_W'(1);
            w_co_base_d = w_co_base_q + WCoStride;
         end
      end
   end

   always_comb begin
      cin_done_seen_d = cin_done_seen_q;
      if (c_load_i || cout_i) begin
         cin_done_seen_d = 1'b0;
      end else if (cin_i && cin_done) begin
         cin_done_seen_d = 1'b1;
      end
      proto_err_d = proto_err_q | multi_hot(strobes) | (cin_i & Single)
                  | ((|strobes) & all_done_q) | (cin_i & cin_done & cin_done_seen_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ci_cnt_q        <= '0;
         ci_idx_q        <= '0;
         co_idx_q        <= '0;
         w_co_base_q     <= '0;
         first_pass_q    <= 1'b0;
         last_pass_q     <= 1'b0;
         all_done_q      <= 1'b0;
         proto_err_q     <= 1'b0;
         cin_done_seen_q <= 1'b0;
      end else begin
         ci_cnt_q        <= ci_cnt_d;
         ci_idx_q        <= ci_idx_d;
         co_idx_q        <= co_idx_d;
         w_co_base_q     <= w_co_base_d;
         first_pass_q    <= first_pass_d;
         last_pass_q     <= last_pass_d;
         all_done_q      <= all_done_d;
         proto_err_q     <= proto_err_d;
         cin_done_seen_q <= cin_done_seen_d;
      end
   end

   stride_addr_gen #(.ADDR_W(ADDR_W), .STRIDE(KERNEL_WORDS)) u_w_base (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (c_load_i),
      .load_val_i (w_co_base_q),
      .step_i     (ci_step),
      .q_o        (w_base_o)
   );

   stride_addr_gen #(.ADDR_W(ADDR_W), .STRIDE(IFMAP_WORDS)) u_if_base (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (c_load_i),
      .load_val_i ('0),
      .step_i     (ci_step),
      .q_o        (if_base_o)
   );

   stride_addr_gen #(.ADDR_W(ADDR_W), .STRIDE(OFMAP_WORDS)) u_of_base (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (1'b0),
      .load_val_i ('0),
      .step_i     (co_step),
      .q_o        (of_base_o)
   );

   assign cin_done_o                = cin_done;
   assign cout_done_o               = cout_done;
   assign is_single_input_channel_o = Single;
   assign ci_idx_o                  = ci_idx_q;
   assign co_idx_o                  = co_idx_q;
   assign first_pass_o              = first_pass_q;
   assign last_pass_o               = last_pass_q;
   assign all_done_o                = all_done_q;
   assign proto_err_o               = proto_err_q;

endmodule
